// File: rtl/hazard_stall_ctrl.sv
// rtl/hazard_stall_ctrl.sv - hazard detection and pipeline sequencing for the 5-stage CPU
module hazard_stall_ctrl #(
  parameter int MULT_CYCLES = 4,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             LoadInstructions,
  input  logic [4:0]       ID_Rs,
  input  logic [4:0]       ID_Rt,
  input  logic             ID_UsesRt,
  input  logic             ID_IsBranch,
  input  logic             ID_IsMult,
  input  logic             ID_ReadsHiLo,
  input  logic             BranchTaken,
  input  logic             EX_MemRead,
  input  logic             EX_RegWrite,
  input  logic [4:0]       EX_Dest,
  input  logic             MEM_MemRead,
  input  logic [4:0]       MEM_Dest,
  output logic             PCWrite,
  output logic             IFID_Enable,
  output logic             HazardMuxSelect,
  output logic             IF_Flush,
  output logic             MultBusy,
  output logic [CNT_W-1:0] StallCycles
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;

  localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);

  logic [1:0]       state_q, state_d;
  logic [3:0]       busy_q, busy_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic             in_run;
  logic             ex_nonzero, mem_nonzero;
  logic             ex_match_rs, ex_match_rt;
  logic             mem_match_rs, mem_match_rt;
  logic             lu_hazard, br_hazard, hl_hazard;
  logic             stall;

  assign in_run = (state_q == ST_RUN);

  // Register-match terms; $0 is hardwired so it never creates a dependency.
  always_comb begin
    ex_nonzero   = (EX_Dest != 5'd0);
    mem_nonzero  = (MEM_Dest != 5'd0);
    ex_match_rs  = ex_nonzero  && (EX_Dest == ID_Rs);
    ex_match_rt  = ex_nonzero  && (EX_Dest == ID_Rt);
    mem_match_rs = mem_nonzero && (MEM_Dest == ID_Rs);
    mem_match_rt = mem_nonzero && (MEM_Dest == ID_Rt);
  end

  // Hazard classes: load-use, ID-stage branch compare, and HI/LO while the multiplier works.
  always_comb begin
    lu_hazard = EX_MemRead && (ex_match_rs || (ID_UsesRt && ex_match_rt));
    br_hazard = ID_IsBranch &&
                ((EX_RegWrite && (ex_match_rs || ex_match_rt)) ||
                 (MEM_MemRead && (mem_match_rs || mem_match_rt)));
    hl_hazard = MultBusy && (ID_ReadsHiLo || ID_IsMult);
    stall     = in_run && (lu_hazard || br_hazard || hl_hazard);
  end

  // Pipeline control outputs; outside RUN the front end is frozen and bubbles are injected.
  always_comb begin
    PCWrite         = 1'b0;
    IFID_Enable     = 1'b0;
    HazardMuxSelect = 1'b1;
    IF_Flush        = 1'b0;
    if (in_run && !stall) begin
      PCWrite         = 1'b1;
      IFID_Enable     = 1'b1;
      HazardMuxSelect = 1'b0;
      // A taken branch only flushes once its operands are ready.
      IF_Flush        = BranchTaken;
    end
  end

  // Sequencing FSM: IDLE after reset, LOAD while imem is written, RUN otherwise.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: state_d = LoadInstructions ? ST_LOAD : ST_RUN;
      ST_LOAD: state_d = LoadInstructions ? ST_LOAD : ST_RUN;
      ST_RUN:  state_d = LoadInstructions ? ST_LOAD : ST_RUN;
      default: state_d = ST_IDLE;
    endcase
  end

  // HI/LO busy counter: reloads on an issued mult, drains to zero, cleared on entering LOAD.
  always_comb begin
    busy_d = busy_q;
    if (state_d == ST_LOAD && state_q != ST_LOAD) begin
      busy_d = 4'd0;
    end else if (in_run && ID_IsMult && !stall) begin
      busy_d = MULT_LOAD;
    end else if (busy_q != 4'd0) begin
      busy_d = busy_q - 4'd1;
    end
  end

  // Saturating count of RUN cycles spent stalled.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state_q     <= ST_IDLE;
      busy_q      <= 4'd0;
      stall_cnt_q <= {CNT_W{1'b0}};
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign MultBusy    = (busy_q != 4'd0);
  assign StallCycles = stall_cnt_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb/tb_hazard_stall_ctrl.sv - directed self-checking bench for hazard_stall_ctrl
`timescale 1ns/1ps
module tb_hazard_stall_ctrl;

  logic        clk;
  logic        Reset;
  logic        LoadInstructions;
  logic [4:0]  ID_Rs, ID_Rt;
  logic        ID_UsesRt, ID_IsBranch, ID_IsMult, ID_ReadsHiLo, BranchTaken;
  logic        EX_MemRead, EX_RegWrite;
  logic [4:0]  EX_Dest;
  logic        MEM_MemRead;
  logic [4:0]  MEM_Dest;
  logic        PCWrite, IFID_Enable, HazardMuxSelect, IF_Flush, MultBusy;
  logic [15:0] StallCycles;

  int checks = 0;
  int errors = 0;
  int exp_stalls = 0;

  hazard_stall_ctrl #(.MULT_CYCLES(4), .CNT_W(16)) dut (
    .clk(clk), .Reset(Reset), .LoadInstructions(LoadInstructions),
    .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UsesRt(ID_UsesRt), .ID_IsBranch(ID_IsBranch),
    .ID_IsMult(ID_IsMult), .ID_ReadsHiLo(ID_ReadsHiLo), .BranchTaken(BranchTaken),
    .EX_MemRead(EX_MemRead), .EX_RegWrite(EX_RegWrite), .EX_Dest(EX_Dest),
    .MEM_MemRead(MEM_MemRead), .MEM_Dest(MEM_Dest),
    .PCWrite(PCWrite), .IFID_Enable(IFID_Enable), .HazardMuxSelect(HazardMuxSelect),
    .IF_Flush(IF_Flush), .MultBusy(MultBusy), .StallCycles(StallCycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_inputs();
    ID_Rs = 5'd0; ID_Rt = 5'd0; ID_UsesRt = 1'b0; ID_IsBranch = 1'b0;
    ID_IsMult = 1'b0; ID_ReadsHiLo = 1'b0; BranchTaken = 1'b0;
    EX_MemRead = 1'b0; EX_RegWrite = 1'b0; EX_Dest = 5'd0;
    MEM_MemRead = 1'b0; MEM_Dest = 5'd0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    Reset = 1'b0; LoadInstructions = 1'b0; clear_inputs();
    #12;
    checks++;
    if ({PCWrite, IFID_Enable, HazardMuxSelect, IF_Flush, MultBusy} !== 5'b00100) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 00100",
               {PCWrite, IFID_Enable, HazardMuxSelect, IF_Flush, MultBusy});
    end
    checks++;
    if (StallCycles !== 16'd0) begin
      errors++; $display("FAIL reset_count: got %0d expected 0", StallCycles);
    end
    LoadInstructions = 1'b1;
    @(negedge clk);
    Reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (PCWrite !== 1'b0 || HazardMuxSelect !== 1'b1) begin
        errors++; $display("FAIL load_hold cyc%0d: PCWrite=%b HMS=%b expected 0/1", i, PCWrite, HazardMuxSelect);
      end
    end
    EX_MemRead = 1'b1; EX_Dest = 5'd3; ID_Rs = 5'd3;
    tick();
    checks++;
    if (StallCycles !== 16'd0) begin
      errors++; $display("FAIL load_no_count: got %0d expected 0", StallCycles);
    end
    clear_inputs();
    LoadInstructions = 1'b0;
    #1;
    checks++;
    if (PCWrite !== 1'b0) begin
      errors++; $display("FAIL load_release_same_cycle: PCWrite=%b expected 0", PCWrite);
    end
    tick();
    checks++;
    if ({PCWrite, IFID_Enable, HazardMuxSelect} !== 3'b110) begin
      errors++; $display("FAIL enter_run: got %b expected 110", {PCWrite, IFID_Enable, HazardMuxSelect});
    end
  endtask

  task automatic test_load_use();
    EX_MemRead = 1'b1; EX_Dest = 5'd3; ID_Rs = 5'd3; #1;
    checks++;
    if ({PCWrite, IFID_Enable, HazardMuxSelect} !== 3'b001) begin
      errors++; $display("FAIL lu_stall: got %b expected 001", {PCWrite, IFID_Enable, HazardMuxSelect});
    end
    tick(); exp_stalls++;
    EX_MemRead = 1'b0; EX_Dest = 5'd0; #1;
    checks++;
    if ({PCWrite, HazardMuxSelect} !== 2'b10) begin
      errors++; $display("FAIL lu_release: got %b expected 10", {PCWrite, HazardMuxSelect});
    end
    checks++;
    if (StallCycles !== 16'd1) begin
      errors++; $display("FAIL lu_count: got %0d expected 1", StallCycles);
    end
    EX_MemRead = 1'b1; EX_Dest = 5'd0; ID_Rs = 5'd0; ID_Rt = 5'd0; ID_UsesRt = 1'b1; #1;
    checks++;
    if (HazardMuxSelect !== 1'b0) begin
      errors++; $display("FAIL lu_reg0: HMS=%b expected 0", HazardMuxSelect);
    end
    EX_Dest = 5'd7; ID_Rs = 5'd1; ID_Rt = 5'd7; ID_UsesRt = 1'b0; #1;
    checks++;
    if (HazardMuxSelect !== 1'b0) begin
      errors++; $display("FAIL lu_rt_unused: HMS=%b expected 0", HazardMuxSelect);
    end
    ID_UsesRt = 1'b1; #1;
    checks++;
    if (HazardMuxSelect !== 1'b1) begin
      errors++; $display("FAIL lu_rt_used: HMS=%b expected 1", HazardMuxSelect);
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_branch();
    ID_IsBranch = 1'b1; ID_Rs = 5'd2; ID_Rt = 5'd5; BranchTaken = 1'b1;
    EX_RegWrite = 1'b1; EX_Dest = 5'd5; #1;
    checks++;
    if ({PCWrite, HazardMuxSelect, IF_Flush} !== 3'b010) begin
      errors++; $display("FAIL br_stall: got %b expected 010", {PCWrite, HazardMuxSelect, IF_Flush});
    end
    tick(); exp_stalls++;
    EX_RegWrite = 1'b0; EX_Dest = 5'd0; #1;
    checks++;
    if ({PCWrite, IF_Flush} !== 2'b11) begin
      errors++; $display("FAIL br_flush: got %b expected 11", {PCWrite, IF_Flush});
    end
    MEM_MemRead = 1'b1; MEM_Dest = 5'd2; #1;
    checks++;
    if ({HazardMuxSelect, IF_Flush} !== 2'b10) begin
      errors++; $display("FAIL br_mem_load: got %b expected 10", {HazardMuxSelect, IF_Flush});
    end
    ID_IsBranch = 1'b0; BranchTaken = 1'b0; #1;
    checks++;
    if (HazardMuxSelect !== 1'b0) begin
      errors++; $display("FAIL nonbranch_mem: HMS=%b expected 0", HazardMuxSelect);
    end
    clear_inputs();
    tick();
    checks++;
    if (StallCycles !== exp_stalls[15:0]) begin
      errors++; $display("FAIL br_count: got %0d expected %0d", StallCycles, exp_stalls);
    end
  endtask

  task automatic test_mult();
    ID_IsMult = 1'b1; #1;
    checks++;
    if ({MultBusy, PCWrite} !== 2'b01) begin
      errors++; $display("FAIL mult_issue: got %b expected 01", {MultBusy, PCWrite});
    end
    tick();
    ID_IsMult = 1'b0; ID_Rs = 5'd9; #1;
    checks++;
    if ({MultBusy, HazardMuxSelect} !== 2'b10) begin
      errors++; $display("FAIL mult_busy_indep: got %b expected 10", {MultBusy, HazardMuxSelect});
    end
    ID_IsMult = 1'b1; #1;
    checks++;
    if (HazardMuxSelect !== 1'b1) begin
      errors++; $display("FAIL mult_while_busy: HMS=%b expected 1", HazardMuxSelect);
    end
    ID_IsMult = 1'b0;
    tick();
    ID_ReadsHiLo = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if ({MultBusy, PCWrite, HazardMuxSelect} !== 3'b101) begin
        errors++; $display("FAIL mfhi_stall cyc%0d: got %b expected 101", i, {MultBusy, PCWrite, HazardMuxSelect});
      end
      tick(); exp_stalls++;
    end
    checks++;
    if ({MultBusy, PCWrite, HazardMuxSelect} !== 3'b010) begin
      errors++; $display("FAIL mfhi_release: got %b expected 010", {MultBusy, PCWrite, HazardMuxSelect});
    end
    clear_inputs();
    tick();
    checks++;
    if (StallCycles !== exp_stalls[15:0]) begin
      errors++; $display("FAIL mult_count: got %0d expected %0d", StallCycles, exp_stalls);
    end
  endtask

  task automatic test_saturation();
    EX_MemRead = 1'b1; EX_Dest = 5'd4; ID_Rs = 5'd4;
    repeat (65536 + 3) tick();
    checks++;
    if (StallCycles !== 16'hFFFF) begin
      errors++; $display("FAIL stall_saturate: got %h expected ffff", StallCycles);
    end
    tick();
    checks++;
    if (StallCycles !== 16'hFFFF) begin
      errors++; $display("FAIL stall_saturate_hold: got %h expected ffff", StallCycles);
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_load_mid_mult();
    ID_IsMult = 1'b1;
    tick();
    ID_IsMult = 1'b0; LoadInstructions = 1'b1; #1;
    checks++;
    if ({MultBusy, PCWrite} !== 2'b11) begin
      errors++; $display("FAIL pre_load_busy: got %b expected 11", {MultBusy, PCWrite});
    end
    tick();
    checks++;
    if ({MultBusy, PCWrite, HazardMuxSelect} !== 3'b001) begin
      errors++; $display("FAIL load_clears_busy: got %b expected 001", {MultBusy, PCWrite, HazardMuxSelect});
    end
    LoadInstructions = 1'b0; #1;
    checks++;
    if (PCWrite !== 1'b0) begin
      errors++; $display("FAIL load_exit_wait: PCWrite=%b expected 0", PCWrite);
    end
    tick();
    checks++;
    if (PCWrite !== 1'b1) begin
      errors++; $display("FAIL load_exit_run: PCWrite=%b expected 1", PCWrite);
    end
  endtask

  task automatic test_async_reset();
    ID_IsMult = 1'b1;
    tick();
    ID_IsMult = 1'b0;
    #2;
    Reset = 1'b0;
    #1;
    checks++;
    if ({PCWrite, HazardMuxSelect, MultBusy} !== 3'b010 || StallCycles !== 16'd0) begin
      errors++; $display("FAIL async_reset: ctrl=%b cnt=%h expected 010/0000",
                         {PCWrite, HazardMuxSelect, MultBusy}, StallCycles);
    end
    @(negedge clk);
    Reset = 1'b1;
    tick();
    tick();
    checks++;
    if (PCWrite !== 1'b1) begin
      errors++; $display("FAIL restart_run: PCWrite=%b expected 1", PCWrite);
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch();
    test_mult();
    test_saturation();
    test_load_mid_mult();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
